// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB bridge master side.
//   apb_state_t   : master FSM states
//   PPROT_DEFAULT : protection attributes driven on every transfer
//   req_*/rsp_*   : widths and bit offsets of the packed request
//                   {write, addr, wdata, strb} and response
//                   {timeout, slverr, rdata} words
//   cnt_w         : wait-counter width for a given timeout
package apb_bridge_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    function automatic int unsigned strb_w(int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned req_w(int unsigned addr_w, int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // strb sits at bit 0 of the request word
    function automatic int unsigned req_wdata_lsb(int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned req_addr_lsb(int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int unsigned req_write_bit(int unsigned addr_w, int unsigned data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

    function automatic int unsigned rsp_w(int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned rsp_slverr_bit(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned rsp_timeout_bit(int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned cnt_w(int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// Bundle of the request/response FIFO handshakes and the APB4 bus seen by
// the master FSM.
//   master : FSM side (pops requests, pushes responses, drives APB)
//   slave  : environment side (FIFOs and APB completer)
interface apb_master_fsm_if
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic [req_w(ADDR_W, DATA_W)-1:0] req_data;
    logic                             req_empty;
    logic                             req_pop;
    logic [rsp_w(DATA_W)-1:0]         rsp_data;
    logic                             rsp_full;
    logic                             rsp_push;

    logic                             PSEL;
    logic                             PENABLE;
    logic                             PWRITE;
    logic [ADDR_W-1:0]                PADDR;
    logic [DATA_W-1:0]                PWDATA;
    logic [strb_w(DATA_W)-1:0]        PSTRB;
    logic [2:0]                       PPROT;
    logic [DATA_W-1:0]                PRDATA;
    logic                             PREADY;
    logic                             PSLVERR;

    modport master (
        input  req_data, req_empty, rsp_full, PRDATA, PREADY, PSLVERR,
        output req_pop, rsp_data, rsp_push,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output req_data, req_empty, rsp_full, PRDATA, PREADY, PSLVERR,
        input  req_pop, rsp_data, rsp_push,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS wait-state counter.
//   clk, rst : clock, async active-low reset
//   clr      : zero the count (start of a transfer)
//   en       : one more PREADY=0 cycle in ACCESS
//   expired  : this enabled cycle is the TIMEOUT-th wait; never set when TIMEOUT=0
module apb_timeout_counter
    import apb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     CntW    = cnt_w(TIMEOUT);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle the count would reach TIMEOUT, so ACCESS lasts exactly TIMEOUT cycles.
    assign expired = (TIMEOUT != 0) && en && (cnt_q == CntLast);

endmodule

// File: rtl/apb_master_fsm.sv
// APB4 master: pops one packed request, runs SETUP/ACCESS (with wait states
// and a PREADY timeout), then pushes a packed response.
//   clk, rst : clock, async active-low reset
//   bus      : request/response FIFO handshakes and APB4 signals (master modport)
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    apb_master_fsm_if.master bus
);

    localparam int unsigned StrbW    = strb_w(DATA_W);
    localparam int unsigned WdataLsb = req_wdata_lsb(DATA_W);
    localparam int unsigned AddrLsb  = req_addr_lsb(DATA_W);
    localparam int unsigned WriteBit = req_write_bit(ADDR_W, DATA_W);
    localparam int unsigned RspW     = rsp_w(DATA_W);

    apb_state_t        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [StrbW-1:0]  pstrb_q, pstrb_d;
    logic [RspW-1:0]   rsp_q, rsp_d;

    logic pop, push, psel, penable, cnt_clr, cnt_en, expired;

    apb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rsp_d    = rsp_q;
        pop      = 1'b0;
        push     = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.req_empty) begin
                    pop      = 1'b1;
                    cnt_clr  = 1'b1;
                    pwrite_d = bus.req_data[WriteBit];
                    paddr_d  = bus.req_data[AddrLsb +: ADDR_W];
                    pwdata_d = bus.req_data[WdataLsb +: DATA_W];
                    pstrb_d  = bus.req_data[WriteBit] ? bus.req_data[0 +: StrbW] : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // A real completion takes priority over a timeout in the same cycle.
                if (bus.PREADY) begin
                    rsp_d   = {1'b0, bus.PSLVERR, pwrite_q ? {DATA_W{1'b0}} : bus.PRDATA};
                    state_d = RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        rsp_d   = {1'b1, 1'b1, {DATA_W{1'b0}}};
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (!bus.rsp_full) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rsp_q    <= rsp_d;
        end
    end

    // Reset holds the FSM in IDLE, where pop would otherwise follow req_empty.
    assign bus.req_pop  = pop & rst;
    assign bus.rsp_push = push;
    assign bus.rsp_data = rsp_q;
    assign bus.PSEL     = psel;
    assign bus.PENABLE  = penable;
    assign bus.PWRITE   = pwrite_q;
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.PSTRB    = pstrb_q;
    assign bus.PPROT    = PPROT_DEFAULT;

endmodule

// File: tb/tb_apb_master_fsm.sv
module tb_apb_master_fsm;
    import apb_bridge_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    apb_master_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic psel, input logic pen,
                       input logic pop, input logic push);
        check({tag, ".psel"}, 64'(bus.PSEL), 64'(psel));
        check({tag, ".penable"}, 64'(bus.PENABLE), 64'(pen));
        check({tag, ".pop"}, 64'(bus.req_pop), 64'(pop));
        check({tag, ".push"}, 64'(bus.rsp_push), 64'(push));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [68:0] mk_req(input logic w, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] s);
        return {w, a, d, s};
    endfunction

    initial begin
        bus.req_data  = '0;
        bus.req_empty = 1'b1;
        bus.rsp_full  = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        ctl("rst", 0, 0, 0, 0);
        check("rst.paddr", 64'(bus.PADDR), 64'h0);
        check("rst.rsp", 64'(bus.rsp_data), 64'h0);
        check("rst.pprot", 64'(bus.PPROT), 64'h0);
        rst = 1'b1;
        tick();

        // Zero-wait write; PRDATA must not leak into a write response
        bus.req_data  = mk_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        bus.req_empty = 1'b0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'hAAAA5555;
        #1 ctl("w.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        #1 ctl("w.c1", 1, 0, 0, 0);
        check("w.paddr", 64'(bus.PADDR), 64'h10);
        check("w.pwrite", 64'(bus.PWRITE), 64'h1);
        check("w.pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
        check("w.pstrb1", 64'(bus.PSTRB), 64'hF);
        tick();
        #1 ctl("w.c2", 1, 1, 0, 0);
        check("w.pstrb2", 64'(bus.PSTRB), 64'hF);
        tick();
        #1 ctl("w.c3", 0, 0, 0, 1);
        check("w.rsp", 64'(bus.rsp_data), 64'h0);
        tick();
        #1 ctl("w.c4", 0, 0, 0, 0);
        check("w.paddr_hold", 64'(bus.PADDR), 64'h10);

        // Read with 3 wait states
        bus.req_data  = mk_req(1'b0, 32'h20, 32'hCAFEF00D, 4'hF);
        bus.req_empty = 1'b0;
        bus.PREADY    = 1'b0;
        #1 ctl("r.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        #1 ctl("r.c1", 1, 0, 0, 0);
        check("r.pstrb", 64'(bus.PSTRB), 64'h0);
        check("r.pwrite", 64'(bus.PWRITE), 64'h0);
        check("r.paddr", 64'(bus.PADDR), 64'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 ctl("r.wait", 1, 1, 0, 0);
        end
        tick();
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h12345678;
        #1 ctl("r.acc4", 1, 1, 0, 0);
        tick();
        bus.PREADY = 1'b0;
        #1 ctl("r.resp", 0, 0, 0, 1);
        check("r.rsp", 64'(bus.rsp_data), 64'h0_12345678);
        tick();
        #1 ctl("r.idle", 0, 0, 0, 0);

        // Read with PSLVERR, then response FIFO full for 5 cycles
        bus.req_data  = mk_req(1'b0, 32'h24, 32'h0, 4'h0);
        bus.req_empty = 1'b0;
        #1 ctl("e.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 32'h55AA55AA;
        #1 ctl("e.c1", 1, 0, 0, 0);
        tick();
        #1 ctl("e.c2", 1, 1, 0, 0);
        tick();
        bus.rsp_full  = 1'b1;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = 32'h0;
        bus.req_data  = mk_req(1'b1, 32'h99, 32'h1, 4'h1);
        bus.req_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 ctl("e.full", 0, 0, 0, 0);
            check("e.rsp_hold", 64'(bus.rsp_data), 64'h1_55AA55AA);
            tick();
        end
        bus.rsp_full  = 1'b0;
        bus.req_empty = 1'b1;
        #1 ctl("e.push", 0, 0, 0, 1);
        check("e.rsp", 64'(bus.rsp_data), 64'h1_55AA55AA);
        tick();
        #1 ctl("e.idle", 0, 0, 0, 0);

        // Timeout: PREADY held low
        bus.req_data  = mk_req(1'b0, 32'h30, 32'h0, 4'h0);
        bus.req_empty = 1'b0;
        bus.PRDATA    = 32'hFFFFFFFF;
        #1 ctl("t.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        #1 ctl("t.c1", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 ctl("t.acc", 1, 1, 0, 0);
        end
        tick();
        #1 ctl("t.resp", 0, 0, 0, 1);
        check("t.rsp", 64'(bus.rsp_data), 64'h3_00000000);
        tick();
        #1 ctl("t.idle", 0, 0, 0, 0);

        // PREADY in the final allowed cycle wins over the timeout
        bus.req_data  = mk_req(1'b0, 32'h34, 32'h0, 4'h0);
        bus.req_empty = 1'b0;
        #1 ctl("v.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        #1 ctl("v.c1", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 ctl("v.wait", 1, 1, 0, 0);
        end
        tick();
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h0BADCAFE;
        #1 ctl("v.acc4", 1, 1, 0, 0);
        tick();
        bus.PREADY = 1'b0;
        #1 ctl("v.resp", 0, 0, 0, 1);
        check("v.rsp", 64'(bus.rsp_data), 64'h0_0BADCAFE);
        tick();
        #1 ctl("v.idle", 0, 0, 0, 0);

        // Reset during ACCESS drops the transfer
        bus.req_data  = mk_req(1'b1, 32'h40, 32'h11223344, 4'h3);
        bus.req_empty = 1'b0;
        #1 ctl("x.c0", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        #1 ctl("x.c1", 1, 0, 0, 0);
        tick();
        #1 ctl("x.acc", 1, 1, 0, 0);
        bus.req_data  = mk_req(1'b0, 32'h50, 32'h0, 4'h0);
        bus.req_empty = 1'b0;
        rst = 1'b0;
        #1 ctl("x.rst", 0, 0, 0, 0);
        check("x.paddr", 64'(bus.PADDR), 64'h0);
        check("x.pwdata", 64'(bus.PWDATA), 64'h0);
        check("x.pstrb", 64'(bus.PSTRB), 64'h0);
        check("x.pwrite", 64'(bus.PWRITE), 64'h0);
        check("x.rsp", 64'(bus.rsp_data), 64'h0);
        tick();
        #1 ctl("x.hold", 0, 0, 0, 0);
        rst = 1'b1;
        #1 ctl("x.rel", 0, 0, 1, 0);
        tick();
        bus.req_empty = 1'b1;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'h00000077;
        #1 ctl("x.setup", 1, 0, 0, 0);
        check("x.paddr2", 64'(bus.PADDR), 64'h50);
        tick();
        #1 ctl("x.access", 1, 1, 0, 0);
        tick();
        #1 ctl("x.resp", 0, 0, 0, 1);
        check("x.rsp2", 64'(bus.rsp_data), 64'h0_00000077);
        tick();
        #1 ctl("x.idle", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
